// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, taken-branch and
// data-memory-wait hazards, plus saturating perf counters and a sticky wait timeout.
module pipeline_hazard_controller #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           idRs1Index,
    input  logic [4:0]           idRs2Index,
    input  logic                 idUsesRs1,
    input  logic                 idUsesRs2,
    input  logic                 exMemRead,
    input  logic [4:0]           exWriteRegisterIndex,
    input  logic                 exBranchTaken,
    input  logic                 memReq,
    input  logic                 memReady,
    output logic                 pcStall,
    output logic                 ifIdStall,
    output logic                 ifIdFlush,
    output logic                 idExStall,
    output logic                 idExFlush,
    output logic                 exMemStall,
    output logic                 memWbBubble,
    output logic                 memTimeout,
    output logic [CNT_WIDTH-1:0] stallCycles,
    output logic [CNT_WIDTH-1:0] flushCount
);

    localparam int unsigned       WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                 mem_timeout_q, mem_timeout_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

    logic mem_stall;
    logic load_use;
    logic branch_flush;

    // Hazard detection is purely combinational so a wait stalls in its request cycle.
    always_comb begin
        mem_stall    = memReq & ~memReady;
        load_use     = exMemRead & (exWriteRegisterIndex != 5'd0) &
                       ((idUsesRs1 & (idRs1Index == exWriteRegisterIndex)) |
                        (idUsesRs2 & (idRs2Index == exWriteRegisterIndex)));
        branch_flush = exBranchTaken & ~mem_stall;
    end

    // Barrier controls in priority order; a masked branch/load-use re-fires once memory is ready.
    always_comb begin
        pcStall     = 1'b0;
        ifIdStall   = 1'b0;
        ifIdFlush   = 1'b0;
        idExStall   = 1'b0;
        idExFlush   = 1'b0;
        exMemStall  = 1'b0;
        memWbBubble = 1'b0;
        if (rst) begin
            ifIdFlush   = 1'b1;
            idExFlush   = 1'b1;
            memWbBubble = 1'b1;
        end else if (mem_stall) begin
            pcStall     = 1'b1;
            ifIdStall   = 1'b1;
            idExStall   = 1'b1;
            exMemStall  = 1'b1;
            memWbBubble = 1'b1;
        end else if (exBranchTaken) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
        end else if (load_use) begin
            pcStall   = 1'b1;
            ifIdStall = 1'b1;
            idExFlush = 1'b1;
        end
    end

    // Wait FSM, timeout detection and saturating performance counters.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = '0;
        mem_timeout_d  = mem_timeout_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (memReady) begin
                    state_d = RUN;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            default: state_d = RUN;
        endcase
        if (wait_cnt_d == WAIT_MAX) begin
            mem_timeout_d = 1'b1;
        end
        if (pcStall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
        end
        if (branch_flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign memTimeout  = mem_timeout_q;
    assign stallCycles = stall_cycles_q;
    assign flushCount  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed hazard scenarios
// followed by randomized traffic against a behavioural reference model.
module tb_pipeline_hazard_controller;

    localparam int unsigned CNT_WIDTH   = 6;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int          CNT_MAX     = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [4:0]           idRs1Index, idRs2Index, exWriteRegisterIndex;
    logic                 idUsesRs1, idUsesRs2, exMemRead, exBranchTaken, memReq, memReady;
    logic                 pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall;
    logic                 memWbBubble, memTimeout;
    logic [CNT_WIDTH-1:0] stallCycles, flushCount;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_known   = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;
    bit m_timeout = 1'b0;
    bit m_in_wait = 1'b0;
    int m_wait_len = 0;

    pipeline_hazard_controller #(
        .CNT_WIDTH  (CNT_WIDTH),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .idRs1Index          (idRs1Index),
        .idRs2Index          (idRs2Index),
        .idUsesRs1           (idUsesRs1),
        .idUsesRs2           (idUsesRs2),
        .exMemRead           (exMemRead),
        .exWriteRegisterIndex(exWriteRegisterIndex),
        .exBranchTaken       (exBranchTaken),
        .memReq              (memReq),
        .memReady            (memReady),
        .pcStall             (pcStall),
        .ifIdStall           (ifIdStall),
        .ifIdFlush           (ifIdFlush),
        .idExStall           (idExStall),
        .idExFlush           (idExFlush),
        .exMemStall          (exMemStall),
        .memWbBubble         (memWbBubble),
        .memTimeout          (memTimeout),
        .stallCycles         (stallCycles),
        .flushCount          (flushCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        idRs1Index = 5'd0; idRs2Index = 5'd0; idUsesRs1 = 1'b0; idUsesRs2 = 1'b0;
        exMemRead = 1'b0; exWriteRegisterIndex = 5'd0; exBranchTaken = 1'b0;
        memReq = 1'b0; memReady = 1'b0;
    endtask

    // Check one cycle against the model, then advance the model across the clock edge.
    task automatic run_cycle(input string tag);
        bit e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs, e_bub;
        bit mstall, luse;
        logic [6:0] exp_v, obs_v;
        #3;
        mstall = memReq && !memReady;
        luse = exMemRead && (exWriteRegisterIndex != 0) &&
               ((idUsesRs1 && idRs1Index == exWriteRegisterIndex) ||
                (idUsesRs2 && idRs2Index == exWriteRegisterIndex));
        {e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs, e_bub} = '0;
        if (rst) begin
            e_iff = 1; e_idf = 1; e_bub = 1;
        end else if (mstall) begin
            e_pc = 1; e_ifs = 1; e_ids = 1; e_exs = 1; e_bub = 1;
        end else if (exBranchTaken) begin
            e_iff = 1; e_idf = 1;
        end else if (luse) begin
            e_pc = 1; e_ifs = 1; e_idf = 1;
        end
        exp_v = {e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs, e_bub};
        obs_v = {pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall, memWbBubble};
        check({tag, "/ctrl"}, 32'(obs_v), 32'(exp_v));
        if (m_known) begin
            check({tag, "/stallCycles"}, 32'(stallCycles), 32'(m_stall));
            check({tag, "/flushCount"}, 32'(flushCount), 32'(m_flush));
            check({tag, "/memTimeout"}, 32'(memTimeout), 32'(m_timeout));
        end
        @(posedge clk);
        if (rst) begin
            m_known = 1; m_stall = 0; m_flush = 0; m_timeout = 0; m_in_wait = 0; m_wait_len = 0;
        end else begin
            if (e_pc && m_stall < CNT_MAX) m_stall++;
            if (exBranchTaken && !mstall && m_flush < CNT_MAX) m_flush++;
            if (m_in_wait) begin
                if (memReady) begin
                    m_in_wait = 0; m_wait_len = 0;
                end else begin
                    if (m_wait_len < int'(MEM_TIMEOUT)) m_wait_len++;
                    if (m_wait_len == int'(MEM_TIMEOUT)) m_timeout = 1;
                end
            end else if (mstall) begin
                m_in_wait = 1; m_wait_len = 0;
            end
        end
        #1;
    endtask

    initial begin
        bit prev_stall;
        idle_inputs();
        rst = 1'b1;
        run_cycle("reset0");
        run_cycle("reset1");
        rst = 1'b0;
        check("reset_stallCycles", 32'(stallCycles), 32'd0);
        check("reset_flushCount", 32'(flushCount), 32'd0);
        check("reset_memTimeout", 32'(memTimeout), 32'd0);

        // Load-use on rs2, then the same with x0 as destination
        exMemRead = 1; exWriteRegisterIndex = 5'd5; idRs2Index = 5'd5; idUsesRs2 = 1;
        run_cycle("loaduse");
        idle_inputs();
        run_cycle("loaduse_after");
        check("loaduse_stallCycles", 32'(stallCycles), 32'd1);
        exMemRead = 1; exWriteRegisterIndex = 5'd0; idRs2Index = 5'd0; idUsesRs2 = 1;
        run_cycle("loaduse_x0");
        check("loaduse_x0_stallCycles", 32'(stallCycles), 32'd1);

        // Branch beats load-use
        exMemRead = 1; exWriteRegisterIndex = 5'd9; idRs1Index = 5'd9; idUsesRs1 = 1;
        exBranchTaken = 1;
        run_cycle("branch_vs_lu");
        idle_inputs();
        run_cycle("branch_after");
        check("branch_flushCount", 32'(flushCount), 32'd1);
        check("branch_stallCycles", 32'(stallCycles), 32'd1);

        // Three-cycle memory wait
        memReq = 1; memReady = 0;
        repeat (3) run_cycle("memwait");
        memReady = 1;
        run_cycle("memwait_ready");
        idle_inputs();
        run_cycle("memwait_idle");
        check("memwait_stallCycles", 32'(stallCycles), 32'd4);
        check("memwait_no_timeout", 32'(memTimeout), 32'd0);
        memReq = 1; memReady = 1;
        run_cycle("memwait_zero_stall");
        idle_inputs();

        // Six-cycle wait crosses the timeout
        memReq = 1; memReady = 0;
        repeat (6) run_cycle("timeout_wait");
        memReady = 1;
        run_cycle("timeout_ready");
        idle_inputs();
        repeat (2) run_cycle("timeout_idle");
        check("timeout_sticky", 32'(memTimeout), 32'd1);
        check("timeout_stallCycles", 32'(stallCycles), 32'd10);

        // Branch masked by a memory wait fires when the wait ends
        memReq = 1; memReady = 0; exBranchTaken = 1;
        repeat (2) run_cycle("masked_branch_wait");
        memReady = 1;
        run_cycle("masked_branch_fire");
        idle_inputs();
        run_cycle("masked_branch_idle");
        check("masked_flushCount", 32'(flushCount), 32'd2);
        check("masked_stallCycles", 32'(stallCycles), 32'd12);

        // Reset during a memory wait
        memReq = 1; memReady = 0;
        repeat (2) run_cycle("rstwait_wait");
        rst = 1;
        run_cycle("rstwait_rst");
        idle_inputs();
        run_cycle("rstwait_after");
        check("rstwait_stallCycles", 32'(stallCycles), 32'd0);
        check("rstwait_flushCount", 32'(flushCount), 32'd0);
        check("rstwait_memTimeout", 32'(memTimeout), 32'd0);

        // Randomized traffic; a pending wait keeps its request asserted
        prev_stall = 0;
        for (int i = 0; i < 3000; i++) begin
            idle_inputs();
            rst                  = ($urandom_range(0, 99) == 0);
            idRs1Index           = 5'($urandom_range(0, 7));
            idRs2Index           = 5'($urandom_range(0, 7));
            idUsesRs1            = 1'($urandom_range(0, 1));
            idUsesRs2            = 1'($urandom_range(0, 1));
            exMemRead            = 1'($urandom_range(0, 1));
            exWriteRegisterIndex = 5'($urandom_range(0, 7));
            exBranchTaken        = ($urandom_range(0, 4) == 0);
            if (prev_stall || m_in_wait) begin
                memReq   = 1;
                memReady = ($urandom_range(0, 99) < 15);
            end else begin
                memReq   = ($urandom_range(0, 99) < 30);
                memReady = 1'($urandom_range(0, 1));
            end
            prev_stall = memReq && !memReady && !rst;
            run_cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage RV32 pipeline. It drives the hold (dontUpdate-style) and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB barriers. It resolves three hazard classes:
- load-use data hazards;
- taken-branch control hazards;
- multi-cycle data-memory waits.

It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

## Interface
Parameters:
- CNT_WIDTH, 32, width of performance counters
- MEM_TIMEOUT, 255, consecutive wait cycles before memTimeout sets (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- idRs1Index  in  5  ID-stage source register 1
- idRs2Index  in  5  ID-stage source register 2
- idUsesRs1  in  1  ID instruction reads rs1
- idUsesRs2  in  1  ID instruction reads rs2
- exMemRead  in  1  EX-stage instruction is a load
- exWriteRegisterIndex  in  5  EX-stage destination register
- exBranchTaken  in  1  branch/jump resolved taken in EX
- memReq  in  1  MEM stage presents a data-memory access this cycle
- memReady  in  1  data memory completes the access this cycle
- pcStall  out  1  hold PC
- ifIdStall  out  1  hold IF/ID
- ifIdFlush  out  1  clear IF/ID to NOP
- idExStall  out  1  hold ID/EX (drives its dontUpdate)
- idExFlush  out  1  clear ID/EX control fields (bubble)
- exMemStall  out  1  hold EX/MEM
- memWbBubble  out  1  load a bubble into MEM/WB (RegWrite=0)
- memTimeout  out  1  sticky: a memory wait exceeded MEM_TIMEOUT
- stallCycles  out  CNT_WIDTH  cycles with pcStall=1
- flushCount  out  CNT_WIDTH  taken-branch flushes issued

## Operation
- FSM states: RUN, MEM_WAIT.
  - RUN → MEM_WAIT when memReq=1 and memReady=0.
  - MEM_WAIT → RUN on the cycle memReady=1.
  - Reset → RUN.
- memStall = memReq & ~memReady. It is combinational and valid in both states; it does not wait for the state register.
- loadUse = exMemRead & (exWriteRegisterIndex≠0) & ((idUsesRs1 & idRs1Index==exWriteRegisterIndex) | (idUsesRs2 & idRs2Index==exWriteRegisterIndex)).
- Priority, highest first:
  1. **memStall.** pcStall, ifIdStall, idExStall and exMemStall are all 1. memWbBubble=1. All flushes are 0.
  2. **exBranchTaken.** ifIdFlush=1 and idExFlush=1. No stalls. flushCount increments.
  3. **loadUse.** pcStall=1, ifIdStall=1, idExFlush=1. idExStall=0.
  4. Otherwise all controls are 0.
- A branch or load-use that coincides with memStall is not lost. Its source stages are frozen, so it is re-evaluated and acted on in the first cycle memStall=0.
- Wait counter (internal, width ⌈log2(MEM_TIMEOUT+1)⌉):
  - cleared in RUN;
  - increments each MEM_WAIT cycle with memReady=0, saturating at MEM_TIMEOUT;
  - on reaching MEM_TIMEOUT, memTimeout sets and stays 1 until rst.
  - Stalling continues regardless of the timeout.
- stallCycles increments on every cycle with pcStall=1. flushCount increments on every taken-branch flush. Both saturate at all-ones and do not wrap.
- During rst=1:
  - ifIdFlush=1 and idExFlush=1, so the barriers clear their control fields;
  - all stalls are 0, memWbBubble=1;
  - FSM → RUN, counters and memTimeout → 0.
  - Reset overrides any in-flight memory wait.

## Timing
- All hazard outputs are combinational from current inputs and state. Counters, FSM and memTimeout update on posedge clk.
- Load-use costs exactly 1 bubble cycle. Next cycle the load sits in MEM, loadUse drops, and the dependent instruction advances.
- Taken branch costs 2 flushed slots: IF/ID and ID/EX.
- A memory access with memReady after N cycles stalls for N cycles. memReady in the request cycle gives 0 stall.
- memTimeout rises on the clock edge ending the MEM_TIMEOUT-th consecutive unready wait cycle, counting from MEM_WAIT entry.
- Reset values:
  - stallCycles=0, flushCount=0, memTimeout=0, state=RUN;
  - combinational outputs as stated under rst.

## Test plan
- **Load-use:** exMemRead=1, exWriteRegisterIndex=5, idRs2Index=5, idUsesRs2=1 for 1 cycle → pcStall=ifIdStall=idExFlush=1, idExStall=0, stallCycles 0→1. Same stimulus with index 0 → no stall.
- **Branch vs load-use:** exBranchTaken=1 and loadUse true in the same cycle → ifIdFlush=idExFlush=1, pcStall=0, flushCount 0→1, stallCycles unchanged.
- **Memory wait:** memReq=1, memReady low for 3 cycles then high → all four stalls and memWbBubble high for exactly 3 cycles, stallCycles=3, state returns to RUN.
- **Timeout:** MEM_TIMEOUT=4, memReady low for 6 cycles → memTimeout rises after the 4th wait cycle and stays 1 after memReady. Stall continues through all 6 cycles. Cleared only by rst.
- **Masked branch:** exBranchTaken=1 while memStall=1 for 2 cycles → no flush during the stall; flush pulse on the cycle memStall falls; flushCount=1.
- **Reset mid-wait:** rst asserted in MEM_WAIT with nonzero counters → next cycle all counters 0, memTimeout=0, state RUN. During rst: ifIdFlush=idExFlush=1, stalls 0.
